exhaustive_pattern_sequencer: RTL and testbench
===============================================

EXHAUSTIVE_PATTERN_SEQUENCER -- requirements
Module: exhaustive_pattern_sequencer

Interface
REQ-001 Parameter N_IN, default 5, SHALL set the width of the pattern driven to the circuit under test.
REQ-002 Parameter RESP_W, default 1, SHALL set the width of the sampled response.
REQ-003 Parameter SETTLE_CYC, default 2, range 1..255, SHALL set the cycles between driving a pattern and sampling the response.
REQ-004 Port CK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: single-cycle run request.
REQ-007 Port pat_out, output, N_IN: pattern driven to the circuit-under-test inputs.
REQ-008 Port dut_resp, input, RESP_W: response from the circuit-under-test output.
REQ-009 Port rec_valid, output, 1: record available.
REQ-010 Port rec_ready, input, 1: consumer (logger) accepts the record.
REQ-011 Port rec_pat, output, N_IN: pattern of the current record.
REQ-012 Port rec_resp, output, RESP_W: sampled response of the current record.
REQ-013 Port busy, output, 1: high while a run is in progress.
REQ-014 Port done, output, 1: high after the last record is accepted, until the next start.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, EMIT and DONE.
REQ-016 In IDLE or DONE, start SHALL load pat_out=0, clear the settle counter and enter SETTLE on the next edge.
REQ-017 start SHALL be ignored in SETTLE and EMIT.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles; on its last cycle dut_resp SHALL be registered into rec_resp, pat_out into rec_pat, and the FSM SHALL enter EMIT.
REQ-019 rec_valid SHALL be high in EMIT only.
REQ-020 While rec_valid=1 and rec_ready=0, rec_pat, rec_resp and pat_out SHALL hold stable.
REQ-021 On a handshake (rec_valid and rec_ready) with pat_out below 2^N_IN-1, pat_out SHALL increment by one and the FSM SHALL re-enter SETTLE.
REQ-022 On a handshake with pat_out = 2^N_IN-1, the FSM SHALL enter DONE with pat_out held; the counter SHALL NOT wrap.
REQ-023 Patterns SHALL be issued in ascending binary order, exactly 2^N_IN records per run, with no skipped or duplicated records.
REQ-024 With no stall, the per-pattern period SHALL be SETTLE_CYC+1 cycles.
REQ-025 busy SHALL be high in SETTLE and EMIT; done SHALL be high in DONE only.

Reset
REQ-026 Asserting reset SHALL at any time, including mid-run, force IDLE, pat_out=0, rec_pat=0, rec_resp=0, rec_valid=0, busy=0 and done=0, plus the signature register of REQ-028.
REQ-027 After reset is released, the block SHALL stay in IDLE until start is asserted.

Configuration
REQ-028 With macro SEQ_SIGNATURE_MISR_EN defined, the block SHALL add a 16-bit output sig and a parameter SIG_POLY (default 16'h1021); sig SHALL be cleared on start and, on each handshake, SHALL update as (sig<<1) XOR (sig[15] ? SIG_POLY : 0) XOR zero-extended rec_resp.
REQ-029 Without SEQ_SIGNATURE_MISR_EN, neither sig nor its logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The state enum and the SIG_W=16 and SIG_POLY_DEFAULT constants SHALL live in a shared package, seq_pkg.
REQ-031 The MISR SHALL be a sub-module, seq_misr, instantiated only under SEQ_SIGNATURE_MISR_EN.

Verification
REQ-032 Case 1: N_IN=5, SETTLE_CYC=2, rec_ready=1, start pulse. Required: 32 records with rec_pat 0..31 in order, records 3 cycles apart, done asserted after record 31, busy then 0.
REQ-033 Case 2: random rec_ready stalls of 0-5 cycles. Required: rec_pat and rec_resp held stable during stalls, 32 records total, no duplicates.
REQ-034 Case 3: reset asserted while rec_pat=12 is in EMIT. Required: all outputs 0 in the same cycle and IDLE held; a new start restarts the run at pattern 0.
REQ-035 Case 4: start pulsed during SETTLE and again during EMIT. Required: no effect on the sequence; a start in DONE begins a new run.
REQ-036 Case 5 (SEQ_SIGNATURE_MISR_EN defined): dut_resp tied to 0 gives sig=16'h0000 at done; dut_resp tied to 1 gives sig equal to the model value for 32 updates.
REQ-037 Case 6: dut_resp driven as a known function of pat_out. Required: every record's rec_resp matches that function applied to rec_pat.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the exhaustive pattern sequencer.
//   seq_state_e      : sequencer FSM state encoding
//   SIG_W            : signature register width
//   SIG_POLY_DEFAULT : default feedback polynomial for the signature register
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int              SIG_W            = 16;
    localparam logic [SIG_W-1:0] SIG_POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/seq_misr.sv
// -----------------------------------------------------------------------------
// seq_misr
// Single-input signature register that folds each accepted response into a
// 16-bit signature: sig <= (sig << 1) ^ (sig[15] ? SIG_POLY : 0) ^ data.
// Only instantiated when SEQ_SIGNATURE_MISR_EN is defined.
// Ports:
//   CK     : clock, rising edge
//   reset  : asynchronous active-high reset, clears the signature
//   clear  : synchronous clear (a new run starts)
//   shift  : fold data into the signature this cycle
//   data   : response to fold in, zero-extended to SIG_W
//   sig    : current signature
// -----------------------------------------------------------------------------
module seq_misr
    import seq_pkg::*;
#(
    parameter int               RESP_W   = 1,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEFAULT
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] data_ext;

    assign data_ext = SIG_W'(data);

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (shift) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ data_ext;
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// exhaustive_pattern_sequencer
// Drives every N_IN-bit pattern, in ascending order, to a circuit under test,
// waits SETTLE_CYC cycles, samples its response and offers (pattern, response)
// as a record on a valid/ready interface. A run ends after the all-ones
// pattern is accepted; the pattern counter never wraps.
// Optional feature: define SEQ_SIGNATURE_MISR_EN to add a 16-bit response
// signature output (sig) and parameter SIG_POLY.
// Ports:
//   CK        : clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : single-cycle run request (honoured in IDLE and DONE only)
//   pat_out   : pattern driven to the circuit under test
//   dut_resp  : response from the circuit under test
//   rec_valid : record available (EMIT state)
//   rec_ready : consumer accepts the record
//   rec_pat   : pattern of the current record
//   rec_resp  : sampled response of the current record
//   busy      : run in progress (SETTLE or EMIT)
//   done      : last record accepted, until the next start
//   sig       : response signature (SEQ_SIGNATURE_MISR_EN only)
// -----------------------------------------------------------------------------
module exhaustive_pattern_sequencer
    import seq_pkg::*;
#(
    parameter int N_IN       = 5,
    parameter int RESP_W     = 1,
    parameter int SETTLE_CYC = 2
`ifdef SEQ_SIGNATURE_MISR_EN
    ,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEFAULT
`endif
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   pat_out,
    input  logic [RESP_W-1:0] dut_resp,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_pat,
    output logic [RESP_W-1:0] rec_resp,
`ifdef SEQ_SIGNATURE_MISR_EN
    output logic [SIG_W-1:0]  sig,
`endif
    output logic              busy,
    output logic              done
);

    // Settle counter is 8 bits wide to cover SETTLE_CYC up to 255.
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] PAT_MAX     = {N_IN{1'b1}};

    seq_state_e        state_q, state_d;
    logic [N_IN-1:0]   pat_q, pat_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   rec_pat_q, rec_pat_d;
    logic [RESP_W-1:0] rec_resp_q, rec_resp_d;

    logic start_accept;
    logic handshake;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign handshake    = (state_q == EMIT) && rec_ready;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        rec_pat_d  = rec_pat_q;
        rec_resp_d = rec_resp_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_d   = '0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Last settle cycle: capture the record, response is stable.
                    rec_pat_d  = pat_q;
                    rec_resp_d = dut_resp;
                    state_d    = EMIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    if (pat_q == PAT_MAX) begin
                        // Hold the final pattern; the counter does not wrap.
                        state_d = DONE;
                    end else begin
                        pat_d   = pat_q + N_IN'(1);
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; all registers, including the
    // record, are reset so outputs are defined immediately on reset.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            cnt_q      <= '0;
            rec_pat_q  <= '0;
            rec_resp_q <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            rec_pat_q  <= rec_pat_d;
            rec_resp_q <= rec_resp_d;
        end
    end

    assign pat_out   = pat_q;
    assign rec_pat   = rec_pat_q;
    assign rec_resp  = rec_resp_q;
    assign rec_valid = (state_q == EMIT);
    assign busy      = (state_q == SETTLE) || (state_q == EMIT);
    assign done      = (state_q == DONE);

`ifdef SEQ_SIGNATURE_MISR_EN
    seq_misr #(
        .RESP_W   (RESP_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clear (start_accept),
        .shift (handshake),
        .data  (rec_resp_q),
        .sig   (sig)
    );
`else
    // start_accept and handshake only feed the signature register.
    logic unused_ok;
    assign unused_ok = start_accept ^ handshake;
`endif

endmodule

// File: tb/tb_exhaustive_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_pattern_sequencer
// Self-checking bench for exhaustive_pattern_sequencer (default parameters).
// The expected record stream is simply 0..31 in order, each paired with the
// response the bench's stimulus function assigns to that pattern.
// -----------------------------------------------------------------------------
module tb_exhaustive_pattern_sequencer;

    localparam int N_IN       = 5;
    localparam int RESP_W     = 1;
    localparam int SETTLE_CYC = 2;
    localparam int NREC       = 1 << N_IN;

    logic            CK = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            rec_ready = 1'b0;
    logic [N_IN-1:0] pat_out;
    logic            dut_resp;
    logic            rec_valid;
    logic [N_IN-1:0] rec_pat;
    logic            rec_resp;
    logic            busy;
    logic            done;
`ifdef SEQ_SIGNATURE_MISR_EN
    logic [15:0]     sig;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   resp_mode = 0;   // 0: const 0, 1: const 1, 2: parity, 3: random table
    logic rand_tab [NREC];

    always #5 CK = ~CK;

    // Circuit-under-test stand-in: response is a known function of pat_out.
    assign dut_resp = (resp_mode == 0) ? 1'b0 :
                      (resp_mode == 1) ? 1'b1 :
                      (resp_mode == 2) ? ^pat_out :
                                         rand_tab[pat_out];

    exhaustive_pattern_sequencer #(
        .N_IN       (N_IN),
        .RESP_W     (RESP_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .pat_out   (pat_out),
        .dut_resp  (dut_resp),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_pat   (rec_pat),
        .rec_resp  (rec_resp),
`ifdef SEQ_SIGNATURE_MISR_EN
        .sig       (sig),
`endif
        .busy      (busy),
        .done      (done)
    );

    function automatic logic exp_resp(input int p);
        case (resp_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($countones(p) % 2);
            default: return rand_tab[p];
        endcase
    endfunction

    function automatic logic [15:0] sig_model();
        int s = 0;
        for (int p = 0; p < NREC; p++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 0) ^ int'(exp_resp(p));
        end
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
`ifdef SEQ_SIGNATURE_MISR_EN
        check({tag, "_sig_clear"}, 32'(sig), 32'd0);
`else
        if (tag.len() == 0) $display("[TB] empty tag");
`endif
    endtask

    // Consume records, checking order, content, stall stability and timing.
    task automatic run_records(input string tag, input int stall_max,
                               input bit inject_start, input int stop_at,
                               output bit stopped);
        int              exp_next   = 0;
        int              cyc        = 0;
        int              last_cyc   = 0;
        int              stall_left = 0;
        bit              stalled    = 1'b0;
        logic [N_IN-1:0] held_pat   = '0;
        logic            held_resp  = 1'b0;
        stopped = 1'b0;
        while (exp_next < NREC && cyc < 3000 && !stopped) begin
            @(negedge CK);
            cyc++;
            check({tag, "_busy_done"}, 32'({busy, done}), 32'd2);
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(rec_valid), 32'd1);
                check({tag, "_stall_pat"},   32'(rec_pat),   32'(held_pat));
                check({tag, "_stall_resp"},  32'(rec_resp),  32'(held_resp));
                check({tag, "_stall_patout"}, 32'(pat_out),  32'(held_pat));
                stall_left--;
            end else if (rec_valid) begin
                held_pat  = N_IN'(exp_next);
                held_resp = exp_resp(exp_next);
                check({tag, "_rec_pat"},  32'(rec_pat),  32'(held_pat));
                check({tag, "_rec_resp"}, 32'(rec_resp), 32'(held_resp));
                check({tag, "_pat_out"},  32'(pat_out),  32'(held_pat));
                if (stall_max == 0) begin
                    if (exp_next == 0) check({tag, "_first_lat"}, cyc, SETTLE_CYC);
                    else               check({tag, "_period"}, cyc - last_cyc, SETTLE_CYC + 1);
                end
                last_cyc   = cyc;
                stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
                if (exp_next == stop_at) stopped = 1'b1;
            end
            if (stopped) begin
                rec_ready = 1'b0;
            end else if (rec_valid || stalled) begin
                rec_ready = (stall_left == 0);
                stalled   = (stall_left != 0);
                if (stall_left == 0) exp_next++;
            end else begin
                rec_ready = (stall_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            start = inject_start && ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        if (!stopped) check({tag, "_count"}, exp_next, NREC);
    endtask

    task automatic check_done(input string tag);
        @(negedge CK);
        check({tag, "_done_busy"}, 32'({busy, done}), 32'd1);
        check({tag, "_done_valid"}, 32'(rec_valid), 32'd0);
        check({tag, "_done_patout"}, 32'(pat_out), NREC - 1);
        check({tag, "_done_recpat"}, 32'(rec_pat), NREC - 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_pat_out"},   32'(pat_out),   32'd0);
        check({tag, "_rec_pat"},   32'(rec_pat),   32'd0);
        check({tag, "_rec_resp"},  32'(rec_resp),  32'd0);
        check({tag, "_rec_valid"}, 32'(rec_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    initial begin
        bit stopped;
        foreach (rand_tab[i]) rand_tab[i] = 1'($urandom_range(0, 1));

        // Reset state, then IDLE must hold with no start.
        repeat (2) @(negedge CK);
        check_idle_zero("rst");
        reset = 1'b0;
        repeat (4) @(negedge CK);
        check_idle_zero("idle_hold");

        // Case 1 + 6: no stalls, response = parity of the pattern.
        resp_mode = 2;
        pulse_start("c1");
        run_records("c1", 0, 1'b0, -1, stopped);
        check_done("c1");
        repeat (3) @(negedge CK);
        check("c1_done_sticky", 32'({busy, done}), 32'd1);

        // Case 4: start from DONE begins a new run; starts mid-run are ignored.
        resp_mode = 3;
        pulse_start("c4");
        run_records("c4", 0, 1'b1, -1, stopped);
        check_done("c4");

        // Case 2: random consumer stalls of 0..5 cycles.
        pulse_start("c2");
        run_records("c2", 5, 1'b0, -1, stopped);
        check_done("c2");

        // Case 3: reset while record 12 is waiting in EMIT.
        resp_mode = 2;
        pulse_start("c3");
        run_records("c3", 0, 1'b0, 12, stopped);
        check("c3_reached12", 32'(stopped), 32'd1);
        check("c3_stopped_valid", 32'(rec_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_idle_zero("c3_rst");
        repeat (2) @(negedge CK);
        reset = 1'b0;
        repeat (4) @(negedge CK);
        check_idle_zero("c3_idle");
        pulse_start("c3b");
        run_records("c3b", 0, 1'b0, -1, stopped);
        check_done("c3b");

`ifdef SEQ_SIGNATURE_MISR_EN
        // Case 5: signature for constant responses.
        resp_mode = 0;
        pulse_start("c5a");
        run_records("c5a", 0, 1'b0, -1, stopped);
        check_done("c5a");
        check("c5a_sig", 32'(sig), 32'd0);
        resp_mode = 1;
        pulse_start("c5b");
        run_records("c5b", 2, 1'b0, -1, stopped);
        check_done("c5b");
        check("c5b_sig", 32'(sig), 32'(sig_model()));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
